binary_subtractor: RTL and testbench

- Registered WIDTH-bit two's-complement subtractor. Computes diff = a - b as a + ~b + 1 using a ripple chain of full adders.
- Exposes the final carry-out as the unsigned "no borrow" indicator (1 = result non-negative, a >= b unsigned), plus borrow, zero, signed-overflow and magnitude status.
- Used as a small arithmetic leaf in datapaths needing a difference plus sign/compare information one cycle later.

---
 rtl/binary_sub_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/binary_subtractor.sv | 83 ++++++++
 tb/tb_binary_subtractor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/binary_sub_pkg.sv
// Shared constants and types for the registered binary subtractor.
package binary_sub_pkg;

   localparam int unsigned SUB_WIDTH_DEFAULT = 4;

   typedef struct packed {
      logic carry;
      logic borrow;
      logic zero;
      logic ovf;
   } sub_status_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as a cell of the subtractor's ripple carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/binary_subtractor.sv
// Registered WIDTH-bit subtractor: diff = a + ~b + 1 through a ripple chain, plus
// carry/borrow/zero/overflow status and unsigned magnitude, one cycle of latency.
module binary_subtractor
   import binary_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             carry,
   output logic             borrow,
   output logic             zero,
   output logic             ovf,
   output logic [WIDTH-1:0] mag,
   output logic             out_valid
);

   logic [WIDTH-1:0] b_inv;
   logic [WIDTH-1:0] d;
   logic [WIDTH:0]   c;

   logic [WIDTH-1:0] diff_d, diff_q;
   logic [WIDTH-1:0] mag_d, mag_q;
   sub_status_t      status_d, status_q;
   logic             out_valid_d, out_valid_q;

   assign b_inv = ~b;
   // Carry-in of 1 completes the two's-complement negation of b.
   assign c[0]  = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_inv[i]),
         .cin  (c[i]),
         .s    (d[i]),
         .cout (c[i+1])
      );
   end

   always_comb begin
      diff_d      = diff_q;
      mag_d       = mag_q;
      status_d    = status_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         diff_d          = d;
         // A set carry-out means no borrow, so the raw difference is already |a - b|.
         mag_d           = c[WIDTH] ? d : -d;
         status_d.carry  = c[WIDTH];
         status_d.borrow = ~c[WIDTH];
         status_d.zero   = (d == '0);
         status_d.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         diff_q      <= '0;
         mag_q       <= '0;
         status_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         diff_q      <= diff_d;
         mag_q       <= mag_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign diff      = diff_q;
   assign mag       = mag_q;
   assign carry     = status_q.carry;
   assign borrow    = status_q.borrow;
   assign zero      = status_q.zero;
   assign ovf       = status_q.ovf;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_subtractor.sv
// Scoreboard bench: stimulus pushes integer-arithmetic expectations, a monitor pops on out_valid.
module tb_binary_subtractor;

   localparam int unsigned W   = 4;
   localparam int unsigned MOD = 1 << W;

   typedef struct {
      logic [W-1:0] diff;
      logic         carry;
      logic         borrow;
      logic         zero;
      logic         ovf;
      logic [W-1:0] mag;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] diff;
   logic         carry;
   logic         borrow;
   logic         zero;
   logic         ovf;
   logic [W-1:0] mag;
   logic         out_valid;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   res_t last;
   res_t zero_res;

   always #5 clk = ~clk;

   binary_subtractor #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .diff      (diff),
      .carry     (carry),
      .borrow    (borrow),
      .zero      (zero),
      .ovf       (ovf),
      .mag       (mag),
      .out_valid (out_valid)
   );

   function automatic res_t model(int unsigned ua, int unsigned ub);
      res_t r;
      int   sa;
      int   sb;
      int   sd;
      r.diff   = W'((ua + MOD - ub) % MOD);
      r.carry  = (ua >= ub);
      r.borrow = (ua < ub);
      r.zero   = (ua == ub);
      r.mag    = W'((ua >= ub) ? (ua - ub) : (ub - ua));
      sa       = (ua >= MOD / 2) ? int'(ua) - int'(MOD) : int'(ua);
      sb       = (ub >= MOD / 2) ? int'(ub) - int'(MOD) : int'(ub);
      sd       = sa - sb;
      r.ovf    = (sd < -int'(MOD / 2)) || (sd > int'(MOD / 2) - 1);
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic chk_outs(string tag, res_t e);
      chk({tag, ".diff"},   32'(diff),   32'(e.diff));
      chk({tag, ".carry"},  32'(carry),  32'(e.carry));
      chk({tag, ".borrow"}, 32'(borrow), 32'(e.borrow));
      chk({tag, ".zero"},   32'(zero),   32'(e.zero));
      chk({tag, ".ovf"},    32'(ovf),    32'(e.ovf));
      chk({tag, ".mag"},    32'(mag),    32'(e.mag));
   endtask

   // One cycle of stimulus; reset and idle cycles are checked inline, valid ones by the monitor.
   task automatic op(logic [W-1:0] ta, logic [W-1:0] tb_v, logic v, logic r);
      rst      = r;
      in_valid = v;
      a        = ta;
      b        = tb_v;
      if (r) begin
         last = zero_res;
      end else if (v) begin
         last = model(int'(ta), int'(tb_v));
         exp_q.push_back(last);
      end
      @(negedge clk);
      if (r) begin
         chk_outs("reset", zero_res);
         chk("reset.out_valid", 32'(out_valid), 32'd0);
      end else if (!v) begin
         chk_outs("hold", last);
         chk("hold.out_valid", 32'(out_valid), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      res_t e;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out out_valid=1 want no pending result at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk_outs("result", e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      zero_res = '{default: '0};
      last     = zero_res;
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'b1010;
      b        = '0;

      op(4'b1010, 4'b0000, 1'b1, 1'b1);
      op(4'b1010, 4'b0000, 1'b1, 1'b1);
      op(4'b0000, 4'b0000, 1'b0, 1'b0);

      op(4'b0110, 4'b0101, 1'b1, 1'b0);
      op(4'b1111, 4'b1111, 1'b1, 1'b0);
      op(4'b0011, 4'b0111, 1'b1, 1'b0);
      op(4'b0111, 4'b1000, 1'b1, 1'b0);
      op(4'b1000, 4'b0001, 1'b1, 1'b0);
      op(4'b0000, 4'b1111, 1'b1, 1'b0);
      op(4'b0000, 4'b0000, 1'b0, 1'b0);
      op(4'b0000, 4'b0000, 1'b0, 1'b0);

      // Back-to-back stream cut by a reset carrying an operand that must be discarded.
      op(4'b1100, 4'b0011, 1'b1, 1'b0);
      op(4'b0001, 4'b1110, 1'b1, 1'b0);
      op(4'b1001, 4'b0010, 1'b1, 1'b1);
      op(4'b0000, 4'b0000, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         op(W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
      op(4'b0000, 4'b0000, 1'b0, 1'b0);

      chk("pending_results", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
